// File: rtl/maze_walker.sv
// maze_walker: moves the player tile by tile over a 20x15 wall bitmap and sequences title/levels/win.
// Optional level timer and lose screen are built only when MAZE_TIMEOUT_EN is defined.
module maze_walker #(
    parameter logic [4:0]  START1_X   = 5'd8,
    parameter logic [3:0]  START1_Y   = 4'd1,
    parameter logic [4:0]  START2_X   = 5'd1,
    parameter logic [3:0]  START2_Y   = 4'd1,
    parameter logic [4:0]  START3_X   = 5'd1,
    parameter logic [3:0]  START3_Y   = 4'd1,
    parameter logic [15:0] TIME_LIMIT = 16'd1800
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_tick,
    input  logic [7:0]   keycode,
    input  logic [299:0] C_map,
    output logic [2:0]   count,
    output logic         E_STATE,
    output logic [4:0]   player_x,
    output logic [3:0]   player_y,
    output logic         busy
);
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    typedef enum logic [2:0] {
        S_TITLE,
        S_PLAY,
        S_CHECK,
        S_ADVANCE,
        S_LOST,
        S_WON
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        count_q, count_d;
    logic [4:0]        x_q, x_d;
    logic [3:0]        y_q, y_d;
    logic signed [5:0] tx_q, tx_d;
    logic signed [5:0] ty_q, ty_d;

    logic              is_dir;
    logic signed [5:0] step_x;
    logic signed [5:0] step_y;
    logic              off_grid;
    logic [8:0]        map_idx;
    logic              target_wall;
    logic              timeout;

    always_comb begin
        step_x = 6'sd0;
        step_y = 6'sd0;
        is_dir = 1'b1;
        case (keycode)
            KEY_W:   step_y = -6'sd1;
            KEY_S:   step_y = 6'sd1;
            KEY_A:   step_x = -6'sd1;
            KEY_D:   step_x = 6'sd1;
            default: is_dir = 1'b0;
        endcase
    end

    // Negative targets show up as the sign bit; the low bits only index the map when on-grid.
    assign off_grid    = tx_q[5] || ty_q[5] || (tx_q > 6'sd19) || (ty_q > 6'sd14);
    assign map_idx     = 9'd20 * {5'd0, ty_q[3:0]} + 9'd19 - {4'd0, tx_q[4:0]};
    assign target_wall = C_map[map_idx];

`ifdef MAZE_TIMEOUT_EN
    logic [15:0] timer_q, timer_d;

    // >= keeps the level expiring even if a CHECK-time tick stepped past the last PLAY value.
    assign timeout = (timer_q >= TIME_LIMIT - 16'd1);

    always_comb begin
        timer_d = timer_q;
        case (state_q)
            S_PLAY, S_CHECK: if (frame_tick) timer_d = timer_q + 16'd1;
            default:         timer_d = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign E_STATE = (state_q == S_LOST);
`else
    assign timeout = 1'b0;
    assign E_STATE = 1'b0;

    if (TIME_LIMIT == 16'd0) begin : g_untimed_levels
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        x_d     = x_q;
        y_d     = y_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        case (state_q)
            S_TITLE: begin
                if (keycode == KEY_ENTER) begin
                    count_d = count_q + 3'd1;
                    state_d = S_ADVANCE;
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    if (timeout) begin
                        state_d = S_LOST;
                    end else if (is_dir) begin
                        tx_d    = $signed({1'b0, x_q}) + step_x;
                        ty_d    = $signed({2'b00, y_q}) + step_y;
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                state_d = S_PLAY;
                if (off_grid) begin
                    count_d = count_q + 3'd1;
                    state_d = S_ADVANCE;
                end else if (!target_wall) begin
                    x_d = tx_q[4:0];
                    y_d = ty_q[3:0];
                end
            end
            S_ADVANCE: begin
                // count already holds the new level here
                state_d = S_PLAY;
                case (count_q)
                    3'd1: begin
                        x_d = START1_X;
                        y_d = START1_Y;
                    end
                    3'd2: begin
                        x_d = START2_X;
                        y_d = START2_Y;
                    end
                    3'd3: begin
                        x_d = START3_X;
                        y_d = START3_Y;
                    end
                    default: state_d = S_WON;
                endcase
            end
            S_LOST, S_WON: begin
                if (keycode == KEY_ENTER) begin
                    state_d = S_TITLE;
                    count_d = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            default: state_d = S_TITLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_TITLE;
            count_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
        end
    end

    assign count    = count_q;
    assign player_x = x_q;
    assign player_y = y_q;
    assign busy     = (state_q == S_CHECK);

endmodule

// File: tb/tb_maze_walker.sv
// Scenario bench for maze_walker: scripted test-plan scenarios plus random walks
// checked against a tile-level model of the game rules.
`timescale 1ns/1ps
module tb_maze_walker;
    localparam logic [15:0] TL    = 16'd4;
    localparam logic [7:0]  K_W   = 8'h1A;
    localparam logic [7:0]  K_A   = 8'h04;
    localparam logic [7:0]  K_S   = 8'h16;
    localparam logic [7:0]  K_D   = 8'h07;
    localparam logic [7:0]  K_ENT = 8'h28;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         frame_tick = 1'b0;
    logic [7:0]   keycode = 8'h00;
    logic [299:0] C_map;
    logic [2:0]   count;
    logic         E_STATE;
    logic [4:0]   player_x;
    logic [3:0]   player_y;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit           map_bits [0:4][0:14][0:19];
    logic [299:0] packed_map [0:7];
    int           start_x [0:3] = '{0, 8, 1, 1};
    int           start_y [0:3] = '{0, 1, 1, 1};

    // model state
    int m_level, m_x, m_y, m_timer;
    bit m_lost;

    assign C_map = packed_map[count];

    always #5 Clk = ~Clk;

    maze_walker #(.TIME_LIMIT(TL)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_tick(frame_tick),
        .keycode   (keycode),
        .C_map     (C_map),
        .count     (count),
        .E_STATE   (E_STATE),
        .player_x  (player_x),
        .player_y  (player_y),
        .busy      (busy)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic refresh_maps();
        for (int l = 0; l < 8; l++) packed_map[l] = '0;
        for (int l = 0; l < 5; l++)
            for (int r = 0; r < 15; r++)
                for (int c = 0; c < 20; c++)
                    packed_map[l][20*r + 19 - c] = map_bits[l][r][c];
    endtask

    task automatic clear_maps();
        for (int l = 0; l < 5; l++)
            for (int r = 0; r < 15; r++)
                for (int c = 0; c < 20; c++)
                    map_bits[l][r][c] = 1'b0;
    endtask

    task automatic scripted_maps();
        clear_maps();
        for (int c = 0; c < 20; c++) map_bits[1][0][c] = 1'b1;
        map_bits[1][1][10] = 1'b1;
        refresh_maps();
    endtask

    task automatic apply_reset();
        Reset = 1'b1; keycode = 8'h00; frame_tick = 1'b0;
        step();
        Reset = 1'b0;
    endtask

    task automatic enter_game();
        keycode = K_ENT;
        step();
        keycode = 8'h00;
        step();
    endtask

    task automatic tick_key(input logic [7:0] k);
        keycode = k; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0; keycode = 8'h00;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(); step();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (E_STATE !== 1'b0) begin n_fail++; $display("FAIL reset_estate: got %0b want 0", E_STATE); end
        n_checks++; if (player_x !== 5'd0) begin n_fail++; $display("FAIL reset_x: got %0d want 0", player_x); end
        n_checks++; if (player_y !== 4'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", player_y); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        Reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_enter();
        apply_reset();
        keycode = K_ENT;
        step();
        keycode = 8'h00;
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL enter_count: got %0d want 1", count); end
        step();
        n_checks++; if (player_x !== 5'd8 || player_y !== 4'd1) begin n_fail++; $display("FAIL enter_start: got (%0d,%0d) want (8,1)", player_x, player_y); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL enter_busy: got %0b want 0", busy); end
        n_checks++; if (E_STATE !== 1'b0) begin n_fail++; $display("FAIL enter_estate: got %0b want 0", E_STATE); end
        $display("test_enter done: count=%0d pos=(%0d,%0d)", count, player_x, player_y);
    endtask

    task automatic test_move_right();
        tick_key(K_D);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL right_busy: got %0b want 1", busy); end
        n_checks++; if (player_x !== 5'd8) begin n_fail++; $display("FAIL right_early: got x=%0d want 8", player_x); end
        step();
        n_checks++; if (player_x !== 5'd9 || player_y !== 4'd1) begin n_fail++; $display("FAIL right_move: got (%0d,%0d) want (9,1)", player_x, player_y); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL right_busy_low: got %0b want 0", busy); end
        tick_key(K_D);
        step();
        n_checks++; if (player_x !== 5'd9 || player_y !== 4'd1) begin n_fail++; $display("FAIL right_wall: got (%0d,%0d) want (9,1)", player_x, player_y); end
        $display("test_move_right done: pos=(%0d,%0d)", player_x, player_y);
    endtask

    task automatic test_move_vertical();
        apply_reset();
        enter_game();
        tick_key(K_W);
        step();
        n_checks++; if (player_x !== 5'd8 || player_y !== 4'd1) begin n_fail++; $display("FAIL up_wall: got (%0d,%0d) want (8,1)", player_x, player_y); end
        tick_key(K_S);
        step();
        n_checks++; if (player_x !== 5'd8 || player_y !== 4'd2) begin n_fail++; $display("FAIL down_move: got (%0d,%0d) want (8,2)", player_x, player_y); end
        $display("test_move_vertical done: pos=(%0d,%0d)", player_x, player_y);
    endtask

    task automatic test_level_walk();
        clear_maps();
        refresh_maps();
        apply_reset();
        enter_game();
        tick_key(K_W); step();
        n_checks++; if (player_x !== 5'd8 || player_y !== 4'd0) begin n_fail++; $display("FAIL walk_row0: got (%0d,%0d) want (8,0)", player_x, player_y); end
        tick_key(K_W); step(); step();
        n_checks++; if (count !== 3'd2 || player_x !== 5'd1 || player_y !== 4'd1) begin n_fail++; $display("FAIL walk_lvl2: got count=%0d (%0d,%0d) want 2 (1,1)", count, player_x, player_y); end
        tick_key(K_A); step();
        tick_key(K_A); step(); step();
        n_checks++; if (count !== 3'd3 || player_x !== 5'd1 || player_y !== 4'd1) begin n_fail++; $display("FAIL walk_lvl3: got count=%0d (%0d,%0d) want 3 (1,1)", count, player_x, player_y); end
        tick_key(K_A); step();
        n_checks++; if (player_x !== 5'd0) begin n_fail++; $display("FAIL walk_left_edge: got x=%0d want 0", player_x); end
        tick_key(K_A); step(); step(); step();
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL walk_won: got count=%0d want 4", count); end
        n_checks++; if (E_STATE !== 1'b0) begin n_fail++; $display("FAIL walk_won_estate: got %0b want 0", E_STATE); end
        keycode = K_ENT; step(); keycode = 8'h00;
        n_checks++; if (count !== 3'd0 || player_x !== 5'd0 || player_y !== 4'd0) begin n_fail++; $display("FAIL walk_title: got count=%0d (%0d,%0d) want 0 (0,0)", count, player_x, player_y); end
        $display("test_level_walk done: count=%0d", count);
    endtask

`ifdef MAZE_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        enter_game();
        for (int i = 0; i < 3; i++) begin
            tick_key(8'h00);
            step();
        end
        n_checks++; if (E_STATE !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %0b want 0", E_STATE); end
        tick_key(8'h00);
        n_checks++; if (E_STATE !== 1'b1 || count !== 3'd1) begin n_fail++; $display("FAIL timeout_lost: got E=%0b count=%0d want E=1 count=1", E_STATE, count); end
        keycode = K_ENT; step(); keycode = 8'h00;
        n_checks++; if (E_STATE !== 1'b0 || count !== 3'd0 || player_x !== 5'd0 || player_y !== 4'd0) begin n_fail++; $display("FAIL timeout_title: got E=%0b count=%0d (%0d,%0d) want 0 0 (0,0)", E_STATE, count, player_x, player_y); end
        $display("test_timeout done");
    endtask
`endif

    task automatic test_reset_mid_check();
        scripted_maps();
        apply_reset();
        enter_game();
        tick_key(K_D);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midchk_busy: got %0b want 1", busy); end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        n_checks++; if (count !== 3'd0 || player_x !== 5'd0 || player_y !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL midchk_reset: got count=%0d (%0d,%0d) busy=%0b want 0 (0,0) 0", count, player_x, player_y, busy); end
        step();
        n_checks++; if (player_x !== 5'd0 || player_y !== 4'd0) begin n_fail++; $display("FAIL midchk_nocommit: got (%0d,%0d) want (0,0)", player_x, player_y); end
        $display("test_reset_mid_check done");
    endtask

    task automatic model_play(input logic [7:0] k, input bit tick);
        int dx, dy, nx, ny;
        if (!tick) return;
`ifdef MAZE_TIMEOUT_EN
        if (m_timer == int'(TL) - 1) begin
            m_lost = 1'b1;
            return;
        end
`endif
        m_timer++;
        dx = 0; dy = 0;
        if (k == K_W) dy = -1;
        else if (k == K_S) dy = 1;
        else if (k == K_A) dx = -1;
        else if (k == K_D) dx = 1;
        else return;
        nx = m_x + dx;
        ny = m_y + dy;
        if (nx < 0 || nx > 19 || ny < 0 || ny > 14) begin
            m_level++;
            if (m_level <= 3) begin
                m_x = start_x[m_level];
                m_y = start_y[m_level];
                m_timer = 0;
            end
        end else if (!map_bits[m_level][ny][nx]) begin
            m_x = nx;
            m_y = ny;
        end
    endtask

    task automatic test_random();
        logic [7:0] keys [0:5] = '{K_W, K_A, K_S, K_D, 8'h00, 8'h10};
        logic [7:0] k;
        bit tick;
        clear_maps();
        for (int l = 1; l < 4; l++) begin
            for (int r = 0; r < 15; r++)
                for (int c = 0; c < 20; c++)
                    map_bits[l][r][c] = ($urandom_range(0, 4) == 0);
            map_bits[l][start_y[l]][start_x[l]] = 1'b0;
        end
        refresh_maps();
        apply_reset();
        m_level = 0; m_x = 0; m_y = 0; m_timer = 0; m_lost = 1'b0;
        for (int t = 0; t < 250; t++) begin
            if (m_level == 0 || m_level == 4 || m_lost) begin
                k = K_ENT; tick = 1'b0;
                keycode = k; step(); keycode = 8'h00; step();
                if (m_level == 0) begin
                    m_level = 1; m_x = start_x[1]; m_y = start_y[1]; m_timer = 0;
                end else begin
                    m_level = 0; m_lost = 1'b0; m_x = 0; m_y = 0; m_timer = 0;
                end
            end else begin
                k = keys[$urandom_range(0, 5)];
                tick = ($urandom_range(0, 9) != 0);
                keycode = k; frame_tick = tick;
                step();
                frame_tick = 1'b0; keycode = 8'h00;
                step(); step(); step();
                model_play(k, tick);
            end
            $display("txn %0d key=%02h tick=%0b -> count=%0d E=%0b pos=(%0d,%0d) model count=%0d E=%0b pos=(%0d,%0d)",
                     t, k, tick, count, E_STATE, player_x, player_y, m_level, m_lost, m_x, m_y);
            n_checks++; if (count !== 3'(m_level)) begin n_fail++; $display("FAIL rand_count txn %0d: got %0d want %0d", t, count, m_level); end
            n_checks++; if (E_STATE !== m_lost) begin n_fail++; $display("FAIL rand_estate txn %0d: got %0b want %0b", t, E_STATE, m_lost); end
            n_checks++; if (player_x !== 5'(m_x) || player_y !== 4'(m_y)) begin n_fail++; $display("FAIL rand_pos txn %0d: got (%0d,%0d) want (%0d,%0d)", t, player_x, player_y, m_x, m_y); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy txn %0d: got %0b want 0", t, busy); end
        end
        $display("test_random done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        scripted_maps();
        test_reset();
        test_enter();
        test_move_right();
        test_move_vertical();
        test_level_walk();
`ifdef MAZE_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_check();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
